// File: rtl/board_mem_arbiter.sv
// ---------------------------------------------------------------------------
// board_mem_arbiter
//
// Shares one single-port synchronous board-state RAM between the grid
// renderer and two game-logic requesters. The renderer owns the RAM address
// bus whenever the FSM is in IDLE or ACK. Requester transactions are granted
// only during stable vertical blanking. A round-robin arbiter picks between
// the two requesters, and each requester uses a 4-phase req/ack handshake.
//
// Ports:
//   clk, rst                 pixel clock, asynchronous active-low reset
//   vblnk                    vertical blanking flag from the VGA timing chain
//   render_addr/render_data  renderer cell address / cell state (= mem_rdata)
//   req*/we*/addr*/wdata*    requester transaction (held until ack)
//   ack*                     transaction complete, held until req drops
//   rdata, err               read result / out-of-range flag, valid with ack
//   mem_addr/we/wdata/rdata  RAM interface (read latency 1)
// ---------------------------------------------------------------------------
module board_mem_arbiter #(
  parameter int GRID_SIZE = 10,
  parameter int CELL_W    = 2,
  parameter int ADDR_W    = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vblnk,
  input  logic [ADDR_W-1:0] render_addr,
  output logic [CELL_W-1:0] render_data,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [CELL_W-1:0] wdata0,
  input  logic [CELL_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [CELL_W-1:0] rdata,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [CELL_W-1:0] mem_wdata,
  input  logic [CELL_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, ACK} state_e;

  localparam logic [ADDR_W:0] NUM_CELLS = (ADDR_W + 1)'(GRID_SIZE * GRID_SIZE);

  state_e              state_q,    state_d;
  logic                vblnk_d_q;
  logic                rr_last_q,  rr_last_d;
  logic                grant_q,    grant_d;   // 0 = req0, 1 = req1
  logic [ADDR_W-1:0]   addr_q,     addr_d;
  logic                we_q,       we_d;
  logic [CELL_W-1:0]   wdata_q,    wdata_d;
  logic                err_pend_q, err_pend_d;
  logic                ack0_q,     ack0_d;
  logic                ack1_q,     ack1_d;
  logic                err_q,      err_d;
  logic [CELL_W-1:0]   rdata_q,    rdata_d;
  logic                capture_q,  capture_d;

  // Candidate winner and its request fields, evaluated every cycle.
  logic                win_sel;
  logic [ADDR_W-1:0]   addr_sel;
  logic                we_sel;
  logic [CELL_W-1:0]   wdata_sel;
  logic                oor_sel;
  logic                granted_req;
  logic [CELL_W-1:0]   rd_new;

  // With both requesting, the one that did not win last time goes next.
  assign win_sel     = (req0 && req1) ? ~rr_last_q : req1;
  assign addr_sel    = win_sel ? addr1  : addr0;
  assign we_sel      = win_sel ? we1    : we0;
  assign wdata_sel   = win_sel ? wdata1 : wdata0;
  assign oor_sel     = ({1'b0, addr_sel} >= NUM_CELLS);
  assign granted_req = grant_q ? req1 : req0;

  // The RAM returns the ISSUE-cycle read on mem_rdata during the first ACK
  // cycle. rdata passes it straight through in that cycle and holds the
  // captured copy afterwards, once the renderer has taken the address bus back.
  assign rd_new = err_pend_q ? '0 : mem_rdata;

  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves it unassigned; a missing default here would infer a latch.
    state_d    = state_q;
    rr_last_d  = rr_last_q;
    grant_d    = grant_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    err_pend_d = err_pend_q;
    ack0_d     = ack0_q;
    ack1_d     = ack1_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    capture_d  = 1'b0;

    case (state_q)
      IDLE: begin
        // Both vblnk samples must be high, so a grant is never issued on the
        // cycle blanking begins.
        if (vblnk && vblnk_d_q && (req0 || req1)) begin
          state_d    = ISSUE;
          grant_d    = win_sel;
          rr_last_d  = win_sel;
          addr_d     = addr_sel;
          wdata_d    = wdata_sel;
          err_pend_d = oor_sel;
          we_d       = we_sel && !oor_sel;
        end
      end
      ISSUE: begin
        // Always completes, even if vblnk falls during this cycle.
        state_d   = ACK;
        capture_d = 1'b1;
        err_d     = err_pend_q;
        if (grant_q) ack1_d = 1'b1;
        else         ack0_d = 1'b1;
      end
      ACK: begin
        if (!granted_req) begin
          state_d = IDLE;
          ack0_d  = 1'b0;
          ack1_d  = 1'b0;
          err_d   = 1'b0;
          rdata_d = '0;
        end else if (capture_q) begin
          rdata_d = rd_new;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the values present before the clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      vblnk_d_q  <= 1'b0;
      rr_last_q  <= 1'b1;
      grant_q    <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      err_pend_q <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      capture_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      vblnk_d_q  <= vblnk;
      rr_last_q  <= rr_last_d;
      grant_q    <= grant_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      err_pend_q <= err_pend_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      capture_q  <= capture_d;
    end
  end

  // RAM ownership: the latched request drives the RAM only in ISSUE.
  assign mem_addr    = (state_q == ISSUE) ? addr_q : render_addr;
  assign mem_we      = (state_q == ISSUE) && we_q;
  assign mem_wdata   = wdata_q;
  assign render_data = mem_rdata;

  assign ack0  = ack0_q;
  assign ack1  = ack1_q;
  assign err   = err_q;
  assign rdata = capture_q ? rd_new : rdata_q;

  // A requester must keep req high until it sees ack.
  a_req_held : assert property (@(posedge clk) disable iff (!rst)
    (state_q == ISSUE) |-> granted_req);

endmodule

// File: tb/tb_board_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_board_mem_arbiter
//
// Directed bench for board_mem_arbiter with a behavioural synchronous RAM
// (read latency 1). Inputs change 1 time unit after posedge; outputs are
// sampled on the following negedge.
// ---------------------------------------------------------------------------
module tb_board_mem_arbiter;

  localparam int GRID_SIZE = 10;
  localparam int CELL_W    = 2;
  localparam int ADDR_W    = 7;

  logic              clk = 1'b0;
  logic              rst;
  logic              vblnk;
  logic [ADDR_W-1:0] render_addr;
  logic [CELL_W-1:0] render_data;
  logic              req0, req1, we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [CELL_W-1:0] wdata0, wdata1;
  logic              ack0, ack1;
  logic [CELL_W-1:0] rdata;
  logic              err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [CELL_W-1:0] mem_wdata;
  logic [CELL_W-1:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  board_mem_arbiter #(
    .GRID_SIZE(GRID_SIZE), .CELL_W(CELL_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .vblnk(vblnk),
    .render_addr(render_addr), .render_data(render_data),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Board RAM model; cell 100 holds a sentinel so out-of-range writes show.
  logic [CELL_W-1:0] ram [0:127];
  logic              ram_init;

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 128; i++) ram[i] <= (i == 100) ? 2'd1 : 2'd0;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic raise(input int r, input logic we, input logic [ADDR_W-1:0] a,
                       input logic [CELL_W-1:0] d);
    if (r == 0) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
    else        begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
  endtask

  task automatic drop(input int r);
    if (r == 0) req0 = 1'b0;
    else        req1 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset with random inputs ----------------
    rst = 1'b0; ram_init = 1'b1;
    vblnk = 1'b0; render_addr = '0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vblnk = 1'($urandom); render_addr = 7'($urandom);
      req0 = 1'($urandom); req1 = 1'($urandom);
      we0 = 1'($urandom); we1 = 1'($urandom);
      addr0 = 7'($urandom); addr1 = 7'($urandom);
      wdata0 = 2'($urandom); wdata1 = 2'($urandom);
      mid();
      check("rst_ack0", 32'(ack0), 0);
      check("rst_ack1", 32'(ack1), 0);
      check("rst_mem_we", 32'(mem_we), 0);
      check("rst_err", 32'(err), 0);
      check("rst_rdata", 32'(rdata), 0);
      check("rst_mem_wdata", 32'(mem_wdata), 0);
    end
    tick();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    vblnk = 1'b1; render_addr = 7'd7; ram_init = 1'b0; rst = 1'b1;
    mid();
    check("idle_mem_addr", 32'(mem_addr), 7);
    tick(); tick();

    // ---------------- single write: req0 addr 23 <- 3 ----------------
    tick(); raise(0, 1'b1, 7'd23, 2'd3);
    mid();
    check("wr_idle_mem_we", 32'(mem_we), 0);
    tick(); mid();
    check("wr_issue_mem_we", 32'(mem_we), 1);
    check("wr_issue_mem_addr", 32'(mem_addr), 23);
    check("wr_issue_mem_wdata", 32'(mem_wdata), 3);
    check("wr_issue_ack0", 32'(ack0), 0);
    tick(); mid();
    check("wr_ack0", 32'(ack0), 1);
    check("wr_err", 32'(err), 0);
    check("wr_ack_mem_addr", 32'(mem_addr), 7);
    tick(); drop(0); mid();
    check("wr_ack0_held", 32'(ack0), 1);
    tick(); mid();
    check("wr_ack0_clear", 32'(ack0), 0);
    check("wr_ram23", 32'(ram[23]), 3);

    // ---------------- read back: req1 addr 23 ----------------
    tick(); raise(1, 1'b0, 7'd23, 2'd0);
    tick(); tick(); mid();
    check("rd_ack1", 32'(ack1), 1);
    check("rd_rdata", 32'(rdata), 3);
    check("rd_err", 32'(err), 0);
    tick(); drop(1); mid();
    check("rd_rdata_held", 32'(rdata), 3);
    tick(); mid();
    check("rd_ack1_clear", 32'(ack1), 0);
    check("rd_rdata_clear", 32'(rdata), 0);

    // ---------------- contention: rr_last=1 -> req0, req1, req0 ----------------
    tick(); raise(0, 1'b0, 7'd23, 2'd0); raise(1, 1'b0, 7'd23, 2'd0);
    tick(); tick(); mid();
    check("rr1_ack0", 32'(ack0), 1);
    check("rr1_ack1", 32'(ack1), 0);
    tick(); drop(0);
    tick(); raise(0, 1'b0, 7'd23, 2'd0); mid();
    check("rr_idle_ack0", 32'(ack0), 0);
    tick(); tick(); mid();
    check("rr2_ack1", 32'(ack1), 1);
    check("rr2_ack0", 32'(ack0), 0);
    check("rr2_rdata", 32'(rdata), 3);
    tick(); drop(1);
    tick(); raise(1, 1'b0, 7'd23, 2'd0);
    tick(); tick(); mid();
    check("rr3_ack0", 32'(ack0), 1);
    check("rr3_ack1", 32'(ack1), 0);
    tick(); drop(0); drop(1);
    tick(); tick();

    // ---------------- blanking gate ----------------
    tick(); vblnk = 1'b0; render_addr = 7'd42; raise(1, 1'b0, 7'd5, 2'd0);
    for (int i = 0; i < 4; i++) begin
      tick(); mid();
      check("gate_ack1_low", 32'(ack1), 0);
      check("gate_render_pass", 32'(mem_addr), 42);
    end
    tick(); vblnk = 1'b1; mid();
    check("gate_t0_mem_addr", 32'(mem_addr), 42);
    tick(); mid();
    check("gate_t1_mem_addr", 32'(mem_addr), 42);
    check("gate_t1_ack1", 32'(ack1), 0);
    tick(); mid();
    check("gate_t2_issue_addr", 32'(mem_addr), 5);
    check("gate_t2_ack1", 32'(ack1), 0);
    tick(); mid();
    check("gate_t3_ack1", 32'(ack1), 1);
    check("gate_t3_rdata", 32'(rdata), 0);
    tick(); drop(1);
    tick(); tick();

    // ---------------- out of range write to addr 100 ----------------
    tick(); raise(0, 1'b1, 7'd100, 2'd2);
    tick(); mid();
    check("oor_mem_we", 32'(mem_we), 0);
    tick(); mid();
    check("oor_ack0", 32'(ack0), 1);
    check("oor_err", 32'(err), 1);
    check("oor_rdata", 32'(rdata), 0);
    tick(); drop(0);
    tick(); mid();
    check("oor_err_clear", 32'(err), 0);
    check("oor_ack0_clear", 32'(ack0), 0);
    check("oor_ram100", 32'(ram[100]), 1);

    // ---------------- vblnk falls during ISSUE ----------------
    tick(); raise(0, 1'b1, 7'd50, 2'd2); render_addr = 7'd9;
    tick(); vblnk = 1'b0; mid();
    check("vfall_mem_we", 32'(mem_we), 1);
    check("vfall_mem_addr", 32'(mem_addr), 50);
    tick(); mid();
    check("vfall_ack0", 32'(ack0), 1);
    tick(); drop(0);
    tick(); mid();
    check("vfall_ack0_clear", 32'(ack0), 0);
    check("vfall_ram50", 32'(ram[50]), 2);
    vblnk = 1'b1;
    tick(); tick();

    // ---------------- reset during ISSUE ----------------
    tick(); raise(0, 1'b1, 7'd60, 2'd3);
    tick(); rst = 1'b0; mid();
    check("rstop_mem_we", 32'(mem_we), 0);
    check("rstop_ack0", 32'(ack0), 0);
    check("rstop_mem_addr", 32'(mem_addr), 9);
    tick(); drop(0);
    tick(); rst = 1'b1;
    tick(); tick(); mid();
    check("rstop_ack0_after", 32'(ack0), 0);
    check("rstop_ram60", 32'(ram[60]), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
